ksa_swap_engine: RTL and testbench

- Responder side of the stage start/finish handshake issued by the top-level search controller.
- Implements the RC4 key-scheduling pass. For i = 0..255: j = j + S[i] + key[i mod 3], then swap S[i] and S[j]. S lives in the shared 256x8 S-RAM.
- Runs after the S-init stage and before the PRGA/decrypt stage. Memory port muxing by stage number is external.

---
 rtl/ksa_swap_engine_if.sv | 39 +++
 rtl/ksa_swap_engine.sv | 187 ++++++++++++++++++
 tb/tb_ksa_swap_engine.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ksa_swap_engine_if.sv
// rtl/ksa_swap_engine_if.sv - stage handshake and S-RAM bus bundle for the KSA swap engine
//
// Purpose: groups the controller handshake (start/finish/secret_key) and the
//          shared S-RAM port (s_addr/s_wrdata/s_wren/s_rddata) into one bundle.
// Modports:
//   master - controller + S-RAM side: drives start, secret_key, s_rddata
//   slave  - KSA engine side: drives finish, s_addr, s_wrdata, s_wren
// Optional macro KSA_SWAP_ABORT_EN adds abort (master->slave) and aborted (slave->master).
interface ksa_swap_engine_if;
  logic        start;
  logic        finish;
  logic [23:0] secret_key;
  logic [7:0]  s_addr;
  logic [7:0]  s_wrdata;
  logic        s_wren;
  logic [7:0]  s_rddata;
`ifdef KSA_SWAP_ABORT_EN
  logic        abort;
  logic        aborted;

  modport master (
    output start, secret_key, s_rddata, abort,
    input  finish, s_addr, s_wrdata, s_wren, aborted
  );
  modport slave (
    input  start, secret_key, s_rddata, abort,
    output finish, s_addr, s_wrdata, s_wren, aborted
  );
`else
  modport master (
    output start, secret_key, s_rddata,
    input  finish, s_addr, s_wrdata, s_wren
  );
  modport slave (
    input  start, secret_key, s_rddata,
    output finish, s_addr, s_wrdata, s_wren
  );
`endif
endinterface

// File: rtl/ksa_swap_engine.sv
// rtl/ksa_swap_engine.sv - RC4 key-scheduling pass over the shared 256x8 S-RAM
//
// Purpose: for i = 0..255, j = j + S[i] + key[i mod 3], then swap S[i] and S[j].
//          Responds to a level start from the search controller with a registered finish.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - ksa_swap_engine_if.slave (start, finish, secret_key, s_addr,
//              s_wrdata, s_wren, s_rddata; abort/aborted when enabled)
// Parameter READ_LATENCY: cycles from s_addr valid to s_rddata valid.
// Optional macro KSA_SWAP_ABORT_EN: abort input cancels a pass, aborted flags it in DONE.
module ksa_swap_engine #(
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  ksa_swap_engine_if.slave  bus
);

  localparam int KEY_LEN = 3;
  localparam int WW      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(READ_LATENCY - 1);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_RD_I   = 4'd1;
  localparam logic [3:0] ST_WAIT_I = 4'd2;
  localparam logic [3:0] ST_CALC_J = 4'd3;
  localparam logic [3:0] ST_RD_J   = 4'd4;
  localparam logic [3:0] ST_WAIT_J = 4'd5;
  localparam logic [3:0] ST_WR_I   = 4'd6;
  localparam logic [3:0] ST_WR_J   = 4'd7;
  localparam logic [3:0] ST_NEXT   = 4'd8;
  localparam logic [3:0] ST_DONE   = 4'd9;

  logic [3:0]  r_state;
  logic [7:0]  r_i;
  logic [7:0]  r_j;
  logic [1:0]  r_imod;       // i mod KEY_LEN, stepped alongside i
  logic [7:0]  r_si;
  logic [23:0] r_key;
  logic [WW-1:0] r_wait;
  logic        r_abort_pend;
  logic [7:0]  r_addr;
  logic [7:0]  r_wrdata;
  logic        r_wren;
  logic        r_finish;

  logic [7:0]  w_key_byte;
  logic [7:0]  w_j_next;
  logic        w_abort;
  logic        w_abort_exit;

`ifdef KSA_SWAP_ABORT_EN
  logic r_aborted;
  assign w_abort     = bus.abort;
  assign bus.aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // Key byte 0 is the MSB byte.
  always_comb begin
    w_key_byte = r_key[7:0];
    if (r_imod == 2'd0)      w_key_byte = r_key[23:16];
    else if (r_imod == 2'd1) w_key_byte = r_key[15:8];
  end

  assign w_j_next = r_j + bus.s_rddata + w_key_byte;

  // An abort seen in WR_I is remembered so WR_J still writes and S stays a permutation.
  always_comb begin
    w_abort_exit = 1'b0;
    case (r_state)
      ST_RD_I, ST_WAIT_I, ST_CALC_J, ST_RD_J, ST_WAIT_J, ST_NEXT: w_abort_exit = w_abort;
      ST_WR_J: w_abort_exit = w_abort | r_abort_pend;
      default: w_abort_exit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_i          <= 8'd0;
      r_j          <= 8'd0;
      r_imod       <= 2'd0;
      r_si         <= 8'd0;
      r_key        <= 24'd0;
      r_wait       <= '0;
      r_abort_pend <= 1'b0;
      r_addr       <= 8'd0;
      r_wrdata     <= 8'd0;
      r_wren       <= 1'b0;
      r_finish     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_i          <= 8'd0;
          r_j          <= 8'd0;
          r_imod       <= 2'd0;
          r_wren       <= 1'b0;
          r_abort_pend <= 1'b0;
          if (bus.start) begin
            r_key   <= bus.secret_key;
            r_state <= ST_RD_I;
          end
        end
        ST_RD_I: begin
          r_addr  <= r_i;
          r_wait  <= '0;
          r_state <= ST_WAIT_I;
        end
        ST_WAIT_I: begin
          if (r_wait == WAIT_LAST) r_state <= ST_CALC_J;
          else                     r_wait  <= r_wait + 1'b1;
        end
        ST_CALC_J: begin
          r_si    <= bus.s_rddata;
          r_j     <= w_j_next;
          r_state <= ST_RD_J;
        end
        ST_RD_J: begin
          r_addr  <= r_j;
          r_wait  <= '0;
          r_state <= ST_WAIT_J;
        end
        ST_WAIT_J: begin
          if (r_wait == WAIT_LAST) r_state <= ST_WR_I;
          else                     r_wait  <= r_wait + 1'b1;
        end
        ST_WR_I: begin
          r_addr       <= r_i;
          r_wrdata     <= bus.s_rddata;
          r_wren       <= 1'b1;
          r_abort_pend <= w_abort;
          r_state      <= ST_WR_J;
        end
        ST_WR_J: begin
          r_addr   <= r_j;
          r_wrdata <= r_si;
          r_wren   <= 1'b1;
          r_state  <= ST_NEXT;
        end
        ST_NEXT: begin
          r_wren <= 1'b0;
          if (r_i == 8'd255) begin
            r_finish <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_i     <= r_i + 8'd1;
            r_imod  <= (r_imod == 2'(KEY_LEN - 1)) ? 2'd0 : r_imod + 2'd1;
            r_state <= ST_RD_I;
          end
        end
        ST_DONE: begin
          // Clears the j write issued by an aborted WR_J; a no-op otherwise.
          r_wren <= 1'b0;
          if (!bus.start) begin
            r_finish <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Abort overrides the normal successor; WR_J's write above still issues.
      if (w_abort_exit) begin
        r_finish <= 1'b1;
        r_state  <= ST_DONE;
        if (r_state == ST_NEXT) r_wren <= 1'b0;
      end
    end
  end

`ifdef KSA_SWAP_ABORT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            r_aborted <= 1'b0;
    else if (w_abort_exit)                   r_aborted <= 1'b1;
    else if (r_state == ST_DONE && !bus.start) r_aborted <= 1'b0;
  end
`endif

  assign bus.s_addr   = r_addr;
  assign bus.s_wrdata = r_wrdata;
  assign bus.s_wren   = r_wren;
  assign bus.finish   = r_finish;

endmodule

// File: tb/tb_ksa_swap_engine.sv
// tb/tb_ksa_swap_engine.sv - self-checking bench for ksa_swap_engine with an S-RAM model and golden KSA
module tb_ksa_swap_engine;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ksa_swap_engine_if bus();

  ksa_swap_engine #(.READ_LATENCY(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [23:0] key;
    int          pattern;   // 0 identity, 1 reversed, 2 shuffled
    int          drop_at;   // edge after acceptance at which start drops (0 = hold)
    bit          early;     // check the first swaps mid-pass
  } vec_t;

  logic [7:0] mem [256];
  logic [7:0] exp_final [256];
  wr_t        wq [$];
  int         errors = 0;
  int         checks = 0;
  int         wcount = 0;
  bit         mon_en = 1'b1;

  // S-RAM model: one cycle read latency, write on the clock edge.
  always @(posedge clk) begin
    bus.s_rddata <= mem[bus.s_addr];
    if (bus.s_wren) mem[bus.s_addr] = bus.s_wrdata;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every write the DUT issues is popped against the golden write stream.
  always @(negedge clk) begin
    if (reset_n && bus.s_wren) begin
      wcount++;
      if (mon_en) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_extra: got write addr %0d expected no write", bus.s_addr);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", int'(bus.s_addr), int'(e.addr));
          chk("wr_data", int'(bus.s_wrdata), int'(e.data));
        end
      end
    end
  end

  function automatic void golden(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] j;
    logic [7:0] kb;
    logic [7:0] t;
    s = mem;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = (i % 3 == 0) ? key[23:16] : (i % 3 == 1) ? key[15:8] : key[7:0];
      j = j + s[i] + kb;
      wq.push_back({8'(i), s[j]});
      wq.push_back({j, s[i]});
      t = s[i];
      s[i] = s[j];
      s[j] = t;
    end
    exp_final = s;
  endfunction

  function automatic int perm_missing();
    bit seen [256];
    int miss;
    miss = 0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) seen[mem[k]] = 1'b1;
    for (int k = 0; k < 256; k++) if (!seen[k]) miss++;
    return miss;
  endfunction

  task automatic preload(input int pattern);
    logic [7:0] t;
    int r;
    for (int k = 0; k < 256; k++) mem[k] = (pattern == 1) ? 8'(255 - k) : 8'(k);
    if (pattern == 2) begin
      for (int k = 255; k > 0; k--) begin
        r = $urandom_range(k, 0);
        t = mem[k];
        mem[k] = mem[r];
        mem[r] = t;
      end
    end
  endtask

  task automatic run_pass(input logic [23:0] key, input int drop_at, input bit early);
    int n;
    int mism;
    bit dropped;
    dropped = 1'b0;
    golden(key);
    @(negedge clk);
    wcount = 0;
    bus.start = 1'b1;
    bus.secret_key = key;
    @(posedge clk);
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (early) begin
        if (n == 10) chk("i0_same_addr_S0", int'(mem[0]), 0);
        if (n == 18) chk("i1_same_addr_S1", int'(mem[1]), 1);
        if (n == 26) begin
          chk("i2_S2", int'(mem[2]), 3);
          chk("i2_S3", int'(mem[3]), 2);
        end
      end
      if (drop_at > 0 && n == drop_at) begin
        bus.start = 1'b0;
        bus.secret_key = ~key;
        dropped = 1'b1;
      end
      if (bus.finish) break;
    end
    chk("finish_latency", n, 2048);
    chk("wren_cycles", wcount, 512);
    chk("write_queue_drained", wq.size(), 0);
    mism = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_final[k]) mism++;
    chk("final_S_mismatches", mism, 0);
    chk("perm_missing", perm_missing(), 0);
    if (dropped) begin
      @(posedge clk); #1;
      chk("finish_one_cycle", int'(bus.finish), 0);
    end else begin
      @(posedge clk); #1;
      chk("finish_held", int'(bus.finish), 1);
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("finish_cleared", int'(bus.finish), 0);
    end
    wq.delete();
  endtask

  vec_t vecs [4];

  initial begin
    int n;
    vecs[0] = '{key: 24'h000000, pattern: 0, drop_at: 0,   early: 1'b1};
    vecs[1] = '{key: 24'h000249, pattern: 0, drop_at: 0,   early: 1'b0};
    vecs[2] = '{key: 24'hA5C31F, pattern: 1, drop_at: 0,   early: 1'b0};
    vecs[3] = '{key: 24'h123456, pattern: 2, drop_at: 100, early: 1'b0};

    bus.start = 1'b0;
    bus.secret_key = 24'd0;
`ifdef KSA_SWAP_ABORT_EN
    bus.abort = 1'b0;
`endif
    preload(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_finish", int'(bus.finish), 0);
    chk("reset_wren", int'(bus.s_wren), 0);
    chk("reset_addr", int'(bus.s_addr), 0);
    chk("reset_wrdata", int'(bus.s_wrdata), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      preload(vecs[v].pattern);
      run_pass(vecs[v].key, vecs[v].drop_at, vecs[v].early);
    end

    // A fresh pass after the dropped-start pass, from the current S contents.
    run_pass(24'h0F1E2D, 0, 1'b0);

    // Reset in the middle of a write.
    preload(0);
    golden(24'h5A5A5A);
    @(negedge clk);
    bus.start = 1'b1;
    bus.secret_key = 24'h5A5A5A;
    @(posedge clk);
    n = 0;
    while (n < 703) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wren_before_reset", int'(bus.s_wren), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_wren", int'(bus.s_wren), 0);
    chk("async_reset_finish", int'(bus.finish), 0);
    chk("async_reset_addr", int'(bus.s_addr), 0);
    bus.start = 1'b0;
    wq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_reset_finish", int'(bus.finish), 0);
    chk("idle_after_reset_wren", int'(bus.s_wren), 0);
    preload(0);
    run_pass(24'h5A5A5A, 0, 1'b0);

`ifdef KSA_SWAP_ABORT_EN
    preload(0);
    mon_en = 1'b0;
    @(negedge clk);
    wcount = 0;
    bus.start = 1'b1;
    bus.secret_key = 24'h00C0DE;
    @(posedge clk);
    n = 0;
    while (n < 88) begin
      @(posedge clk); #1;
      n++;
      if (n == 85) bus.abort = 1'b1;
      if (n == 86) bus.abort = 1'b0;
      if (n == 87) begin
        chk("abort_finish", int'(bus.finish), 1);
        chk("abort_aborted", int'(bus.aborted), 1);
      end
    end
    chk("abort_writes", wcount, 22);
    chk("abort_perm_missing", perm_missing(), 0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("abort_finish_clear", int'(bus.finish), 0);
    chk("abort_aborted_clear", int'(bus.aborted), 0);
    mon_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
